ad7643_dual_sequencer: RTL and testbench

- Sequences simultaneous conversions on both AD7643 converters (channels 0 and 1).
- Reads both 18-bit results serially in slave mode using a shared generated SCLK.
- Writes the two results through one shared sample-memory write port: channel 0 first, then channel 1.
- Sits between the USB command decoder (start/stop/count) and the waveform memory, replacing ad-hoc counter-driven ADC strobing.

---
 rtl/ad7643_pkg.sv | 11 +
 rtl/ad7643_serial_rx.sv | 48 ++++
 rtl/ad7643_dual_sequencer.sv | 100 ++++++++++
 tb/tb_ad7643_dual_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7643_pkg.sv
// ad7643_pkg: shared state encoding, widths and timing defaults for the AD7643 dual sequencer
package ad7643_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CNV, S_WAIT_BUSY, S_SHIFT, S_STORE0, S_STORE1, S_GAP} state_t;
  localparam int DATA_W_DEF    = 18;
  localparam int ADRS_W_DEF    = 14;
  localparam int SCLK_HALF_DEF = 3;
  localparam int CNV_LOW_DEF   = 5;
  localparam int BUSY_TMO_DEF  = 255;
  localparam int GAP_DEF       = 4;
  localparam int CNT_W         = 16;
endpackage

// File: rtl/ad7643_serial_rx.sv
// ad7643_serial_rx: shared SCLK generator and two MSB-first shift registers for slave-mode readout
module ad7643_serial_rx #(
  parameter int SCLK_HALF = 3,
  parameter int DATA_W = 18
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              go,
  input  logic              sdout0,
  input  logic              sdout1,
  output logic              sclk,
  output logic [DATA_W-1:0] word0,
  output logic [DATA_W-1:0] word1,
  output logic              rx_done
);
  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam int BW = $clog2(DATA_W + 1);
  logic          active;
  logic [HW-1:0] hcnt;
  logic [BW-1:0] nbits;
  logic          flip;
  assign flip = active && hcnt == HW'(SCLK_HALF - 1);
  // combinational so the FSM leaves SHIFT on the same edge as the last falling SCLK
  assign rx_done = flip && sclk && nbits == BW'(DATA_W - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      active <= 1'b0;
      hcnt <= '0;
      nbits <= '0;
      sclk <= 1'b0;
      word0 <= '0;
      word1 <= '0;
    end else if (go) begin
      active <= 1'b1;
      hcnt <= '0;
      nbits <= '0;
      sclk <= 1'b0;
    end else if (active) begin
      hcnt <= flip ? '0 : hcnt + 1'b1;
      if (flip) sclk <= !sclk;
      if (flip && sclk) begin
        word0 <= {word0[DATA_W-2:0], sdout0};
        word1 <= {word1[DATA_W-2:0], sdout1};
        nbits <= nbits + 1'b1;
        active <= !rx_done;
      end
    end
endmodule

// File: rtl/ad7643_dual_sequencer.sv
// ad7643_dual_sequencer: simultaneous dual AD7643 conversion, serial readout and paired sample-memory writes
module ad7643_dual_sequencer import ad7643_pkg::*; #(
  parameter int SCLK_HALF = SCLK_HALF_DEF,
  parameter int CNV_LOW = CNV_LOW_DEF,
  parameter int BUSY_TMO = BUSY_TMO_DEF,
  parameter int GAP = GAP_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADRS_W = ADRS_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       nframes,
  output logic              adcnvst,
  output logic              adcs,
  output logic              adsclk,
  input  logic              adbusy0,
  input  logic              adbusy1,
  input  logic              adsdout0,
  input  logic              adsdout1,
  output logic              wr_en,
  output logic [ADRS_W-1:0] wr_adrs,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_tmo,
  output logic              wrapped
);
  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        nfr;
  logic [1:0]         b0_s, b1_s;
  logic               stop_l, both_low, tmo, go, rx_done, last;
  logic [DATA_W-1:0]  word0, word1;
  assign both_low = !b0_s[1] && !b1_s[1];
  assign go = state == S_WAIT_BUSY && both_low;
  assign tmo = state == S_WAIT_BUSY && !both_low && cnt == CNT_W'(BUSY_TMO - 1);
  assign last = stop_l || (nframes != '0 && nfr == nframes);
  assign wr_en = state == S_STORE0 || state == S_STORE1;
  assign wr_data = state == S_STORE1 ? word1 : state == S_STORE0 ? word0 : '0;
  assign busy = state != S_IDLE;
  ad7643_serial_rx #(.SCLK_HALF(SCLK_HALF), .DATA_W(DATA_W)) u_rx (
    .CLK(CLK), .RST(RST), .go(go), .sdout0(adsdout0), .sdout1(adsdout1),
    .sclk(adsclk), .word0(word0), .word1(word1), .rx_done(rx_done)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      state_n = start ? S_CNV : S_IDLE;
      S_CNV:       state_n = cnt == CNT_W'(CNV_LOW - 1) ? S_WAIT_BUSY : S_CNV;
      S_WAIT_BUSY: state_n = both_low ? S_SHIFT : tmo ? S_GAP : S_WAIT_BUSY;
      S_SHIFT:     state_n = rx_done ? S_STORE0 : S_SHIFT;
      S_STORE0:    state_n = S_STORE1;
      S_STORE1:    state_n = S_GAP;
      S_GAP:       state_n = cnt == CNT_W'(GAP - 1) ? (last ? S_IDLE : S_CNV) : S_GAP;
      default:     state_n = S_IDLE;
    endcase
  end
  // converter strobes are registered from next-state so the pins never glitch on state decode
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= S_IDLE;
      cnt <= '0;
      nfr <= '0;
      b0_s <= '1;
      b1_s <= '1;
      stop_l <= 1'b0;
      adcnvst <= 1'b1;
      adcs <= 1'b1;
      done <= 1'b0;
      wr_adrs <= '0;
      err_tmo <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      b0_s <= {b0_s[0], adbusy0};
      b1_s <= {b1_s[0], adbusy1};
      stop_l <= state_n == S_IDLE ? 1'b0 : stop_l | (stop && state != S_IDLE);
      adcnvst <= state_n != S_CNV;
      adcs <= state_n != S_SHIFT;
      done <= state == S_GAP && state_n == S_IDLE;
      if (state == S_IDLE && start) begin
        wr_adrs <= '0;
        nfr <= '0;
        err_tmo <= 1'b0;
        wrapped <= 1'b0;
      end
      if (tmo) begin
        err_tmo <= 1'b1;
        nfr <= nfr + 1'b1;
      end
      if (wr_en) begin
        wr_adrs <= wr_adrs + 1'b1;
        if (&wr_adrs) wrapped <= 1'b1;
      end
      if (state == S_STORE1) nfr <= nfr + 1'b1;
    end
endmodule

// File: tb/tb_ad7643_dual_sequencer.sv
// tb_ad7643_dual_sequencer: directed bench with an AD7643 pin model and a write scoreboard
module tb_ad7643_dual_sequencer;
  localparam int SH = 3, CL = 5, TMO = 255, GP = 4, DW = 18, AW = 4, CONV = 40;
  logic CLK = 0, RST = 1, start = 0, stop = 0;
  logic [15:0] nframes = 0;
  logic adbusy0 = 0, adbusy1 = 0, adsdout0 = 0, adsdout1 = 0;
  logic adcnvst, adcs, adsclk, wr_en, busy, done, err_tmo, wrapped;
  logic [AW-1:0] wr_adrs;
  logic [DW-1:0] wr_data;
  int nchk = 0, nerr = 0, ncyc = 0;
  int conv_n = 0, conv_t = CONV + 1, k = 0, tmo_frame = -1;
  logic cnv_q = 1, sclk_q = 0;
  logic [AW-1:0] q_a[$], log_a[$];
  logic [DW-1:0] q_d[$], log_d[$];
  int nwr_run = 0, ndone = 0, start_cyc = 0, first_wr_cyc = 0, done_cyc = 0;
  int lo_run = 0, run = 0, rises = 0, last_fall = 0, cnv_rise_cyc = 0, tmo_delta = 0;
  logic adcs_q = 1, sclk_q2 = 0, err_q = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) ncyc++;

  ad7643_dual_sequencer #(.SCLK_HALF(SH), .CNV_LOW(CL), .BUSY_TMO(TMO), .GAP(GP), .DATA_W(DW), .ADRS_W(AW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .nframes(nframes),
    .adcnvst(adcnvst), .adcs(adcs), .adsclk(adsclk), .adbusy0(adbusy0), .adbusy1(adbusy1),
    .adsdout0(adsdout0), .adsdout1(adsdout1), .wr_en(wr_en), .wr_adrs(wr_adrs), .wr_data(wr_data),
    .busy(busy), .done(done), .err_tmo(err_tmo), .wrapped(wrapped)
  );

  function automatic logic [DW-1:0] adc_word(input int ch, input int n);
    return (ch != 0 ? 18'h15A5A : 18'h2A5A5) ^ DW'(n * 'h1111);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // converter model: BUSY rises with CNVST low, falls CONV cycles after CNVST returns high; data shifts on SCLK falls
  always @(posedge CLK) begin
    logic [DW-1:0] w0, w1;
    #1;
    if (!adcnvst && cnv_q) conv_n++;
    if (!adcnvst) begin
      adbusy0 = 1;
      adbusy1 = 1;
      conv_t = 0;
    end else begin
      if (conv_t == CONV) begin
        adbusy0 = 0;
        adbusy1 = (conv_n - 1 == tmo_frame);
      end
      if (conv_t <= CONV) conv_t++;
    end
    if (adcs) k = 0;
    else if (sclk_q && !adsclk) k++;
    w0 = adc_word(0, conv_n - 1);
    w1 = adc_word(1, conv_n - 1);
    adsdout0 = k < DW ? w0[DW-1-k] : 1'b0;
    adsdout1 = k < DW ? w1[DW-1-k] : 1'b0;
    cnv_q = adcnvst;
    sclk_q = adsclk;
  end

  always @(negedge CLK) begin
    if (RST) begin
      adcs_q = 1;
      sclk_q2 = 0;
      lo_run = 0;
      err_q = 0;
    end else begin
      if (wr_en) begin
        chk("write_expected", q_a.size() != 0, 1);
        if (q_a.size() != 0) begin
          chk("wr_adrs", wr_adrs, q_a.pop_front());
          chk("wr_data", wr_data, q_d.pop_front());
        end
        chk("wrapped_flag", wrapped, nwr_run >= 2**AW);
        if (nwr_run == 0) first_wr_cyc = ncyc;
        log_a.push_back(wr_adrs);
        log_d.push_back(wr_data);
        nwr_run++;
      end
      if (!adcnvst) lo_run++;
      else if (lo_run > 0) begin
        chk("cnvst_low_cycles", lo_run, CL);
        lo_run = 0;
        cnv_rise_cyc = ncyc;
      end
      if (!adcs && adcs_q) begin
        run = 1;
        rises = 0;
      end else if (!adcs_q) begin
        if (adsclk != sclk_q2) begin
          chk("sclk_half_period", run, SH);
          run = 1;
          if (adsclk) rises++;
          else last_fall = ncyc;
        end else run++;
        if (adcs) begin
          chk("sclk_rising_edges", rises, DW);
          chk("cs_rise_after_last_fall", ncyc - last_fall <= 1, 1);
        end
      end
      if (adcs) chk("sclk_low_while_cs_high", adsclk, 0);
      if (err_tmo && !err_q) tmo_delta = ncyc - cnv_rise_cyc;
      if (done) begin
        chk("busy_low_at_done", busy, 0);
        ndone++;
        done_cyc = ncyc;
      end
      adcs_q = adcs;
      sclk_q2 = adsclk;
      err_q = err_tmo;
    end
  end

  task automatic push_frame(input int n, input int adrs);
    q_a.push_back(AW'(adrs));
    q_d.push_back(adc_word(0, n));
    q_a.push_back(AW'(adrs + 1));
    q_d.push_back(adc_word(1, n));
  endtask

  task automatic pulse_start(input int nf, input logic with_stop);
    nframes = 16'(nf);
    nwr_run = 0;
    conv_n = 0;
    log_a.delete();
    log_d.delete();
    @(posedge CLK);
    #1 start = 1;
    stop = with_stop;
    start_cyc = ncyc + 1;
    @(posedge CLK);
    #1 start = 0;
    stop = 0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = ndone;
    for (int i = 0; i < budget && ndone == d0; i++) @(posedge CLK);
    chk("done_within_budget", ndone > d0, 1);
    @(negedge CLK);
    chk("done_one_cycle", done, 0);
    chk("all_writes_seen", q_a.size(), 0);
  endtask

  task automatic wait_shift(input int frame, input int budget);
    for (int i = 0; i < budget && !(conv_n == frame && !adcs); i++) @(negedge CLK);
    chk("reached_shift", conv_n == frame && !adcs, 1);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_ctl", {adcnvst, adcs, adsclk, wr_en, busy, done, err_tmo, wrapped}, 8'b1100_0000);
    chk("reset_adrs", wr_adrs, 0);
    chk("reset_data", wr_data, 0);
    #2 RST = 0;

    push_frame(0, 0);
    pulse_start(1, 0);
    wait_done(1000);
    chk("single_write_count", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("single_w0_adrs", log_a[0], 0);
      chk("single_w0_data", log_d[0], 18'h2A5A5);
      chk("single_w1_adrs", log_a[1], 1);
      chk("single_w1_data", log_d[1], 18'h15A5A);
    end
    chk("first_write_latency", first_wr_cyc - start_cyc, 156);
    chk("done_latency", done_cyc - start_cyc, 162);
    chk("single_conversions", conv_n, 1);

    @(posedge CLK);
    #1 stop = 1;
    @(posedge CLK);
    #1 stop = 0;
    push_frame(0, 0);
    push_frame(1, 2);
    pulse_start(2, 1);
    repeat (50) @(posedge CLK);
    #1 start = 1;
    @(posedge CLK);
    #1 start = 0;
    wait_done(1000);
    chk("idle_stop_ignored_frames", conv_n, 2);

    tmo_frame = 0;
    push_frame(1, 0);
    pulse_start(2, 0);
    wait_done(2000);
    chk("tmo_flag", err_tmo, 1);
    chk("tmo_delay", tmo_delta, 255);
    chk("tmo_first_adrs", log_a.size() > 0 ? log_a[0] : 4'hF, 0);
    tmo_frame = -1;

    for (int f = 0; f < 3; f++) push_frame(f, 2 * f);
    pulse_start(0, 0);
    wait_shift(3, 2000);
    repeat (20) @(posedge CLK);
    #1 stop = 1;
    @(posedge CLK);
    #1 stop = 0;
    wait_done(1000);
    chk("stop_write_count", nwr_run, 6);
    chk("stop_err_cleared", err_tmo, 0);
    repeat (300) @(posedge CLK);
    chk("stop_no_more_cnvst", conv_n, 3);
    chk("stop_idle", busy, 0);

    for (int i = 0; i < 18; i++) begin
      q_a.push_back(AW'(i));
      q_d.push_back(adc_word(i % 2, i / 2));
    end
    pulse_start(9, 0);
    wait_done(3000);
    chk("wrap_write_count", nwr_run, 18);
    chk("wrap_flag_end", wrapped, 1);
    chk("wrap_17th_adrs", log_a.size() > 16 ? log_a[16] : 4'hF, 0);

    push_frame(0, 0);
    pulse_start(2, 0);
    wait_shift(2, 2000);
    repeat (10) @(negedge CLK);
    #2 RST = 1;
    #1 chk("async_rst_ctl", {adcs, adsclk, busy, wr_en, adcnvst}, 5'b10001);
    q_a.delete();
    q_d.delete();
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    chk("rst_flags_clear", {err_tmo, wrapped, done}, 3'b000);
    push_frame(0, 0);
    pulse_start(1, 0);
    wait_done(1000);
    chk("restart_adrs", log_a.size() > 0 ? log_a[0] : 4'hF, 0);
    chk("restart_err", err_tmo, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", nerr);
    $fatal(1);
  end
endmodule
